// File: rtl/alarm_pkg.sv
// Constants shared between the PIN verifier and its status reporter:
// status codes, ASCII framing bytes and the fixed message length.
package alarm_pkg;

    typedef logic [2:0] status_code_t;

    localparam status_code_t ST_IDLE   = 3'b000;
    localparam status_code_t ST_OPEN   = 3'b001;
    localparam status_code_t ST_WRONG1 = 3'b010;
    localparam status_code_t ST_WRONG2 = 3'b011;
    localparam status_code_t ST_LOCKED = 3'b100;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam int         MSG_LEN  = 6;
    localparam logic [2:0] MSG_LAST = 3'(MSG_LEN - 1);

endpackage

// File: rtl/status_msg_rom.sv
// Combinational lookup of one byte of the 6-byte status message
// (4 ASCII chars + CR LF) for a given status code and byte index.
module status_msg_rom
    import alarm_pkg::*;
(
    input  logic [2:0] code,
    input  logic [2:0] index,
    output logic [7:0] data
);

    logic [31:0] chars;

    always_comb begin
        chars = "????";
        case (code)
            ST_IDLE:   chars = "IDLE";
            ST_OPEN:   chars = "OPEN";
            ST_WRONG1: chars = "ERR1";
            ST_WRONG2: chars = "ERR2";
            ST_LOCKED: chars = "LOCK";
            default:   chars = "????";
        endcase
    end

    always_comb begin
        data = 8'h00;
        case (index)
            3'd0:    data = chars[31:24];
            3'd1:    data = chars[23:16];
            3'd2:    data = chars[15:8];
            3'd3:    data = chars[7:0];
            3'd4:    data = CHAR_CR;
            3'd5:    data = CHAR_LF;
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/status_uart_reporter.sv
// Reports every change of the verifier status code as a 6-byte ASCII message
// on a valid/ready byte stream, with an optional periodic heartbeat resend.
module status_uart_reporter
    import alarm_pkg::*;
#(
    parameter int HEARTBEAT_CYCLES = 0,
    parameter int HB_W             = 32
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_state,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic [7:0] o_msg_count
);

    // Stream handshake: a byte moves on a rising edge where o_tx_valid and
    // i_tx_ready are both high; o_tx_data is held while valid waits on ready.

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [HB_W-1:0] HB_LAST =
        HB_W'((HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0);

    logic [0:0]      state;
    logic [2:0]      idx;
    logic [2:0]      msg_code;
    logic [2:0]      last_code;
    logic            first;
    logic            pending;
    logic [HB_W-1:0] hb_cnt;
    logic [7:0]      msg_count;
    logic [7:0]      rom_byte;

    logic code_changed;
    logic hb_expired;
    logic start;
    logic xfer;
    logic last_byte;

    status_msg_rom u_rom (
        .code  (msg_code),
        .index (idx),
        .data  (rom_byte)
    );

    assign code_changed = (i_state != last_code);
    assign hb_expired   = (HEARTBEAT_CYCLES > 0) && (hb_cnt == HB_LAST);
    assign start        = first || code_changed || hb_expired;
    assign xfer         = (state == S_SEND) && i_tx_ready;
    assign last_byte    = (idx == MSG_LAST);

    assign o_tx_valid  = (state == S_SEND);
    assign o_busy      = (state == S_SEND);
    assign o_tx_data   = (state == S_SEND) ? rom_byte : 8'h00;
    assign o_msg_count = msg_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            idx       <= 3'd0;
            msg_code  <= ST_IDLE;
            last_code <= ST_IDLE;
            first     <= 1'b1;
            pending   <= 1'b0;
            hb_cnt    <= '0;
            msg_count <= 8'd0;
        end else if (state == S_IDLE) begin
            if (start) begin
                msg_code  <= i_state;
                last_code <= i_state;
                first     <= 1'b0;
                idx       <= 3'd0;
                hb_cnt    <= '0;
                state     <= S_SEND;
            end else if (HEARTBEAT_CYCLES > 0) begin
                hb_cnt <= hb_cnt + HB_W'(1);
            end
        end else begin
            // Only the latest code is remembered; earlier changes are overwritten.
            if (code_changed) begin
                last_code <= i_state;
                pending   <= 1'b1;
            end
            if (xfer) begin
                if (!last_byte) begin
                    idx <= idx + 3'd1;
                end else begin
                    msg_count <= msg_count + 8'd1;
                    idx       <= 3'd0;
                    // A change landing on the final byte is folded into the follow-up message.
                    if (pending || code_changed) begin
                        msg_code <= code_changed ? i_state : last_code;
                        pending  <= 1'b0;
                        hb_cnt   <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_status_uart_reporter.sv
// Directed bench for status_uart_reporter: byte scoreboard, backpressure,
// back-to-back collapse, mid-message reset and heartbeat spacing.
module tb_status_uart_reporter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state;
    logic       ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       busy;
    logic [7:0] msg_count;

    logic [2:0] hb_state;
    logic       hb_ready;
    logic [7:0] hb_data;
    logic       hb_valid;
    logic       hb_busy;
    logic [7:0] hb_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    status_uart_reporter #(.HEARTBEAT_CYCLES(0), .HB_W(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_state     (state),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (ready),
        .o_busy      (busy),
        .o_msg_count (msg_count)
    );

    status_uart_reporter #(.HEARTBEAT_CYCLES(20), .HB_W(8)) dut_hb (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_state     (hb_state),
        .o_tx_data   (hb_data),
        .o_tx_valid  (hb_valid),
        .i_tx_ready  (hb_ready),
        .o_busy      (hb_busy),
        .o_msg_count (hb_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_msg(input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3);
        exp_q.push_back(c0);
        exp_q.push_back(c1);
        exp_q.push_back(c2);
        exp_q.push_back(c3);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic drain_check(input string tag);
        logic [7:0] e;
        logic [31:0] g;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? {24'h0, got_q.pop_front()} : 32'hFFFF;
            check({tag, "_byte"}, g, {24'h0, e});
        end
        got_q.delete();
    endtask

    // Main-DUT monitor: records accepted bytes and checks data hold under stall.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready && tx_valid)
                check("stall_hold", tx_data, prev_data);
            if (tx_valid && ready)
                got_q.push_back(tx_data);
            prev_valid = tx_valid;
            prev_ready = ready;
            prev_data  = tx_data;
        end
    end

    // Heartbeat-DUT monitor: idle gap between messages and repeated byte pattern.
    logic [7:0] hb_exp [6] = '{8'h4F, 8'h50, 8'h45, 8'h4E, 8'h0D, 8'h0A};
    logic hb_check_en = 1'b0;
    logic hb_prev_valid = 1'b0;
    logic hb_seen = 1'b0;
    int   hb_low = 0;
    int   hb_idx = 0;
    int   hb_gaps = 0;
    int   hb_msgs = 0;

    always @(negedge clk) begin
        if (rst) begin
            hb_prev_valid = 1'b0;
            hb_seen = 1'b0;
            hb_low  = 0;
            hb_idx  = 0;
            hb_msgs = 0;
        end else begin
            if (hb_valid) begin
                if (!hb_prev_valid && hb_seen && hb_check_en) begin
                    check("hb_gap", hb_low, 20);
                    hb_gaps++;
                end
                hb_low  = 0;
                hb_seen = 1'b1;
                if (hb_ready) begin
                    if (hb_check_en)
                        check("hb_byte", hb_data, hb_exp[hb_idx]);
                    if (hb_idx == 5) begin
                        hb_idx = 0;
                        hb_msgs++;
                    end else begin
                        hb_idx++;
                    end
                end
            end else begin
                hb_low++;
            end
            hb_prev_valid = hb_valid;
        end
    end

    initial begin
        rst      = 1'b1;
        state    = 3'b000;
        ready    = 1'b1;
        hb_state = 3'b001;
        hb_ready = 1'b1;
        tick(3);

        @(negedge clk);
        check("rst_valid", tx_valid, 1'b0);
        check("rst_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_count", msg_count, 8'd0);

        // Reset release: initial report one cycle after release.
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("first_lat0", tx_valid, 1'b0);
        tick(1);
        @(negedge clk);
        check("first_valid", tx_valid, 1'b1);
        check("first_byte", tx_data, 8'h49);
        tick(10);
        push_msg(8'h49, 8'h44, 8'h4C, 8'h45);
        drain_check("idle_msg");
        exp_count = 1;
        check("idle_count", msg_count, exp_count[7:0]);
        check("idle_busy", busy, 1'b0);

        // IDLE -> OPEN while idle.
        state = 3'b001;
        @(negedge clk);
        check("open_lat0", tx_valid, 1'b0);
        tick(1);
        @(negedge clk);
        check("open_lat1", tx_valid, 1'b1);
        tick(10);
        push_msg(8'h4F, 8'h50, 8'h45, 8'h4E);
        drain_check("open_msg");
        exp_count++;
        check("open_count", msg_count, exp_count[7:0]);

        // LOCK under alternating backpressure.
        state = 3'b100;
        ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            ready = ~ready;
        end
        ready = 1'b1;
        tick(8);
        push_msg(8'h4C, 8'h4F, 8'h43, 8'h4B);
        drain_check("lock_bp");
        exp_count++;
        check("lock_count", msg_count, exp_count[7:0]);

        // ERR1 with two changes during send: ERR2 dropped, LOCK back-to-back.
        state = 3'b010;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (i == 0) state = 3'b011;
            if (i == 1) state = 3'b100;
            @(negedge clk);
            check("b2b_valid", tx_valid, 1'b1);
        end
        tick(6);
        push_msg(8'h45, 8'h52, 8'h52, 8'h31);
        push_msg(8'h4C, 8'h4F, 8'h43, 8'h4B);
        drain_check("collapse");
        exp_count += 2;
        check("collapse_count", msg_count, exp_count[7:0]);

        // Change away and back to the code being sent: message repeats.
        state = 3'b001;
        tick(1);
        state = 3'b000;
        tick(1);
        state = 3'b001;
        tick(14);
        push_msg(8'h4F, 8'h50, 8'h45, 8'h4E);
        push_msg(8'h4F, 8'h50, 8'h45, 8'h4E);
        drain_check("change_back");
        exp_count += 2;
        check("change_back_count", msg_count, exp_count[7:0]);

        // Change on the cycle of the final byte transfer.
        state = 3'b100;
        tick(6);
        state = 3'b010;
        tick(12);
        push_msg(8'h4C, 8'h4F, 8'h43, 8'h4B);
        push_msg(8'h45, 8'h52, 8'h52, 8'h31);
        drain_check("last_byte_change");
        exp_count += 2;
        check("last_byte_count", msg_count, exp_count[7:0]);

        // Reset after byte 2 of OPEN, then a fresh full report.
        state = 3'b001;
        tick(4);
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        check("midrst_valid", tx_valid, 1'b0);
        check("midrst_count", msg_count, 8'd0);
        check("midrst_busy", busy, 1'b0);
        exp_q.push_back(8'h4F);
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h45);
        rst = 1'b0;
        tick(10);
        push_msg(8'h4F, 8'h50, 8'h45, 8'h4E);
        drain_check("midrst_msg");
        exp_count = 1;
        check("midrst_new_count", msg_count, exp_count[7:0]);

        // Heartbeat phase: both DUTs restart; only the HB=20 one repeats.
        rst = 1'b1;
        tick(2);
        hb_check_en = 1'b1;
        rst = 1'b0;
        tick(1000);
        push_msg(8'h4F, 8'h50, 8'h45, 8'h4E);
        drain_check("no_heartbeat");
        check("no_hb_count", msg_count, 8'd1);
        hb_ready = 1'b0;
        tick(2);
        @(negedge clk);
        check("hb_gap_count", (hb_gaps >= 30) ? 1 : 0, 1);
        check("hb_msg_count", hb_count, hb_msgs[7:0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/status_uart_reporter.md
Name: status_uart_reporter

Overview:
Downstream consumer of the PIN verifier's 3-bit system status code. Detects changes of the code and emits a fixed 6-byte ASCII status message (4 chars + CR LF) over a byte-wide valid/ready stream to the UART transmitter. Never drops the most recent status and can optionally re-send it as a periodic heartbeat.

Parameters:
HEARTBEAT_CYCLES, 0, idle cycles between heartbeat re-sends of the last code; 0 disables heartbeat.
HB_W, 32, heartbeat counter width; must hold HEARTBEAT_CYCLES-1.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_state  in  3  status code from verifier: 000 IDLE, 001 OPEN, 010 WRONG1, 011 WRONG2, 100 LOCKED, others invalid
o_tx_data  out  8  ASCII byte to UART TX
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  UART TX accepts byte; transfer = o_tx_valid & i_tx_ready on a rising edge
o_busy  out  1  message in progress (FSM in S_SEND)
o_msg_count  out  8  count of completed messages, wraps 255->0

Behaviour:
- Reset (i_rst=1 at edge): o_tx_valid=0, o_tx_data=8'h00, o_busy=0, o_msg_count=0, byte index=0, pending=0, heartbeat counter=0, r_first=1, r_last_code=000, FSM=S_IDLE.
- Message map (code -> chars): 000 "IDLE", 001 "OPEN", 010 "ERR1", 011 "ERR2", 100 "LOCK", 101/110/111 "????". Bytes 4,5 are 8'h0D, 8'h0A.
- FSM states: S_IDLE, S_SEND.
- S_IDLE trigger, any of: (a) r_first=1; (b) i_state != r_last_code; (c) heartbeat expiry. On trigger: r_msg_code<=i_state, r_last_code<=i_state, r_first<=0, index<=0, heartbeat counter<=0, go S_SEND. o_tx_valid=1 with byte 0 on the very next cycle; latency from code change to first valid = 1 cycle.
- S_SEND: o_tx_valid=1; o_tx_data = map(r_msg_code, index); data held stable while valid & !ready. On transfer of index 0..4: index++. On transfer of index 5: o_msg_count++. Then, if pending=1: r_msg_code<=r_last_code, index<=0, pending<=0, stay S_SEND with valid held high (back-to-back). Else go S_IDLE; valid low next cycle.
- Change during S_SEND: if i_state != r_last_code, then r_last_code<=i_state, pending<=1. Multiple changes within one message collapse to the latest code; intermediate codes are dropped by design. A change back to the code currently being sent still sets pending; the message is sent again.
- Change on the same cycle as the final-byte transfer: the new code is captured into r_last_code with pending=1 and is sent next, back-to-back.
- Heartbeat (HEARTBEAT_CYCLES>0): counter increments only in S_IDLE with no other trigger. On reaching HEARTBEAT_CYCLES-1, triggers a resend of r_last_code. The counter is cleared on every message start. With HEARTBEAT_CYCLES=0 the counter stays 0 and never triggers.
- i_tx_ready held low: the block stalls indefinitely with no timeout; pending tracking continues.
- Reset mid-message: aborts immediately, with valid=0 on the next cycle. After reset, r_first forces a fresh report of the current i_state.
- o_busy = (FSM == S_SEND), registered with the state.

Decomposition:
- Shared package alarm_pkg: 3-bit status code localparams (IDLE/OPEN/WRONG1/WRONG2/LOCKED), shared with the verifier; ASCII constants CR=8'h0D and LF=8'h0A; MSG_LEN=6.
- One sub-module, status_msg_rom: combinational (code[2:0], index[2:0]) -> byte[7:0] lookup. It returns 8'h00 for index > 5.

Test Plan:
- Reset release with i_state=000, i_tx_ready=1 -> bytes 49 44 4C 45 0D 0A ("IDLE\r\n") on 6 consecutive cycles starting 1 cycle after release; o_msg_count=1; o_busy low after the last byte.
- i_state 000->001 while idle, ready=1 -> "OPEN\r\n"; o_tx_valid rises 1 cycle after the change; o_msg_count increments by 1.
- Backpressure: i_tx_ready toggles 0/1 every cycle during "LOCK" -> exactly 6 transfers 4C 4F 43 4B 0D 0A, with o_tx_data stable on every stalled cycle.
- During the "ERR1" send, i_state goes 010->011->100 -> "ERR1\r\n" completes, then "LOCK\r\n" follows back-to-back with valid never dropping; "ERR2" is never sent; count +2.
- HEARTBEAT_CYCLES=20, i_state constant 001 after the initial report -> "OPEN\r\n" repeats, each new message starting 21 cycles after the previous message ended; with HEARTBEAT_CYCLES=0, no repeat within 1000 cycles.
- i_rst asserted after byte 2 of "OPEN" -> valid=0 next cycle, count=0; on release with i_state=001 -> a full "OPEN\r\n" from byte 0.
